// File: rtl/set_compare_unit.sv
// Pipelined set-on-compare unit for the EX stage: signed/unsigned SLT/SLE/SGT/SGE/SEQ/SNE
// or ALU pass-through, with stall/flush support and 1- or 2-cycle latency.
module set_compare_unit #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned PIPE_STAGES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [2:0]       cmp_op,
   input  logic             cmp_unsigned,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [WIDTH-1:0] pass_in,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             flag_lt,
   output logic             flag_eq
);

   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_SLT  = 3'b001,
      OP_SLE  = 3'b010,
      OP_SGT  = 3'b011,
      OP_SGE  = 3'b100,
      OP_SEQ  = 3'b101,
      OP_SNE  = 3'b110,
      OP_RSVD = 3'b111
   } cmp_op_t;

   // Stage A: one subtractor supplies borrow, sign, overflow and equality
   logic [WIDTH:0] diff;
   logic           n_bit;
   logic           v_bit;
   logic           lt_a;
   logic           eq_a;

   always_comb begin
      diff  = {1'b0, op_a} - {1'b0, op_b};
      // A zero low-order difference is exactly op_a == op_b
      eq_a  = (diff[WIDTH-1:0] == '0);
      n_bit = diff[WIDTH-1];
      v_bit = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      lt_a  = cmp_unsigned ? diff[WIDTH] : (n_bit ^ v_bit);
   end

   logic             b_valid;
   logic             b_lt;
   logic             b_eq;
   cmp_op_t          b_op;
   logic [WIDTH-1:0] b_pass;

   generate
      if (PIPE_STAGES >= 2) begin : g_two
         logic             a_valid;
         logic             a_lt;
         logic             a_eq;
         cmp_op_t          a_op;
         logic [WIDTH-1:0] a_pass;

         always_ff @(posedge clk) begin
            if (rst) begin
               a_valid <= 1'b0;
               a_lt    <= 1'b0;
               a_eq    <= 1'b0;
               a_op    <= OP_PASS;
               a_pass  <= '0;
            end else if (flush) begin
               a_valid <= 1'b0;
            end else if (!stall) begin
               a_valid <= in_valid;
               a_lt    <= lt_a;
               a_eq    <= eq_a;
               a_op    <= cmp_op_t'(cmp_op);
               a_pass  <= pass_in;
            end
         end

         assign b_valid = a_valid;
         assign b_lt    = a_lt;
         assign b_eq    = a_eq;
         assign b_op    = a_op;
         assign b_pass  = a_pass;
      end else begin : g_one
         assign b_valid = in_valid;
         assign b_lt    = lt_a;
         assign b_eq    = eq_a;
         assign b_op    = cmp_op_t'(cmp_op);
         assign b_pass  = pass_in;
      end
   endgenerate

   // Stage B: condition select and result formatting
   logic             cond;
   logic             is_cmp;
   logic [WIDTH-1:0] b_result;

   always_comb begin
      cond   = 1'b0;
      is_cmp = 1'b1;
      case (b_op)
         OP_SLT:  cond = b_lt;
         OP_SLE:  cond = b_lt | b_eq;
         OP_SGT:  cond = !b_lt & !b_eq;
         OP_SGE:  cond = !b_lt;
         OP_SEQ:  cond = b_eq;
         OP_SNE:  cond = !b_eq;
         default: is_cmp = 1'b0;
      endcase
      b_result = is_cmp ? {{(WIDTH-1){1'b0}}, cond} : b_pass;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         flag_lt   <= 1'b0;
         flag_eq   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (!stall) begin
         out_valid <= b_valid;
         result    <= b_result;
         flag_lt   <= b_lt;
         flag_eq   <= b_eq;
      end
   end

endmodule

// File: tb/tb_set_compare_unit.sv
// Bench for set_compare_unit: one instance per latency, checked every cycle against
// an arithmetic reference model with directed boundary steps and random traffic.
module tb_set_compare_unit;

   logic        clk = 1'b0;
   logic        rst, stall, flush, in_valid, cmp_unsigned;
   logic [2:0]  cmp_op;
   logic [31:0] op_a, op_b, pass_in;

   logic        ov1, lt1, eq1, ov2, lt2, eq2;
   logic [31:0] res1, res2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   set_compare_unit #(.WIDTH(32), .PIPE_STAGES(1)) u_p1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .cmp_op(cmp_op), .cmp_unsigned(cmp_unsigned), .op_a(op_a), .op_b(op_b),
      .pass_in(pass_in), .out_valid(ov1), .result(res1), .flag_lt(lt1), .flag_eq(eq1)
   );

   set_compare_unit #(.WIDTH(32), .PIPE_STAGES(2)) u_p2 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .cmp_op(cmp_op), .cmp_unsigned(cmp_unsigned), .op_a(op_a), .op_b(op_b),
      .pass_in(pass_in), .out_valid(ov2), .result(res2), .flag_lt(lt2), .flag_eq(eq2)
   );

   typedef struct packed {
      logic        v;
      logic [31:0] res;
      logic        lt;
      logic        eq;
   } ent_t;

   ent_t m1 = '0;
   ent_t m2a = '0;
   ent_t m2b = '0;

   function automatic ent_t ref_op(input logic v, input logic [2:0] op, input logic uns,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] p);
      ent_t e;
      logic c;
      e.v  = v;
      e.lt = uns ? (a < b) : ($signed(a) < $signed(b));
      e.eq = (a == b);
      case (op)
         3'd1:    c = e.lt;
         3'd2:    c = e.lt || e.eq;
         3'd3:    c = !e.lt && !e.eq;
         3'd4:    c = !e.lt;
         3'd5:    c = e.eq;
         3'd6:    c = !e.eq;
         default: c = 1'b0;
      endcase
      e.res = (op == 3'd0 || op == 3'd7) ? p : {31'd0, c};
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string nm, input ent_t m, input logic ov,
                            input logic [31:0] r, input logic l, input logic e,
                            input logic full);
      chk({nm, ".out_valid"}, {31'd0, ov}, {31'd0, m.v});
      if (m.v || full) begin
         chk({nm, ".result"}, r, m.res);
         chk({nm, ".flag_lt"}, {31'd0, l}, {31'd0, m.lt});
         chk({nm, ".flag_eq"}, {31'd0, e}, {31'd0, m.eq});
      end
   endtask

   // One clock: update the reference with the inputs sampled at the edge, then check
   task automatic tick();
      ent_t e;
      logic was_rst;
      @(posedge clk);
      was_rst = rst;
      e = ref_op(in_valid, cmp_op, cmp_unsigned, op_a, op_b, pass_in);
      if (rst) begin
         m1 = '0; m2a = '0; m2b = '0;
      end else if (flush) begin
         m1.v = 1'b0; m2a.v = 1'b0; m2b.v = 1'b0;
      end else if (!stall) begin
         m1  = e;
         m2b = m2a;
         m2a = e;
      end
      #1;
      check_dut("p1", m1, ov1, res1, lt1, eq1, was_rst);
      check_dut("p2", m2b, ov2, res2, lt2, eq2, was_rst);
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic u,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] p);
      in_valid = v; cmp_op = op; cmp_unsigned = u; op_a = a; op_b = b; pass_in = p;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b1, 3'd1, 1'b0, 32'h1, 32'h2, 32'h3);
      tick(); tick();
      rst = 1'b0;

      // Signed vs unsigned on -1 / 1
      drive(1'b1, 3'd1, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0); tick();
      drive(1'b1, 3'd1, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0); tick();
      // Overflow boundaries
      drive(1'b1, 3'd3, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0); tick();
      drive(1'b1, 3'd2, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0); tick();
      drive(1'b1, 3'd4, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0); tick();
      // Pass-through and reserved
      drive(1'b1, 3'd0, 1'b0, 32'h5, 32'h9, 32'hDEAD_BEEF); tick();
      drive(1'b1, 3'd7, 1'b1, 32'h9, 32'h5, 32'h1234_5678); tick();
      for (int op = 1; op <= 6; op++) begin
         drive(1'b1, 3'(op), op[0], pick(), pick(), 32'hFFFF_FFFF); tick();
      end
      drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0); tick(); tick();

      // Back-to-back SEQ/SNE/SLT
      drive(1'b1, 3'd5, 1'b0, 32'd5, 32'd5, 32'h0); tick();
      drive(1'b1, 3'd6, 1'b0, 32'd5, 32'd5, 32'h0); tick();
      drive(1'b1, 3'd1, 1'b0, 32'd3, 32'd4, 32'h0); tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0); tick(); tick(); tick();

      // Stall for three cycles with a different op presented (ignored)
      drive(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'hCAFE_F00D); tick();
      stall = 1'b1;
      drive(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'hBAD0_BAD0);
      tick(); tick(); tick();
      stall = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0); tick(); tick(); tick();

      // Flush together with stall kills the in-flight op
      drive(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h1111_2222); tick();
      flush = 1'b1; stall = 1'b1;
      drive(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'h3333_4444); tick();
      flush = 1'b0; stall = 1'b0;
      drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0); tick(); tick(); tick();

      // Reset with two ops in flight, then SLTU(0, all-ones)
      drive(1'b1, 3'd0, 1'b0, 32'h0, 32'h0, 32'hAAAA_5555); tick();
      drive(1'b1, 3'd3, 1'b0, 32'h9, 32'h1, 32'h0); tick();
      rst = 1'b1;
      drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0); tick();
      rst = 1'b0; tick();
      drive(1'b1, 3'd1, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h0); tick();
      drive(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0); tick(); tick(); tick();

      // Random traffic with occasional stall, flush and reset
      for (int i = 0; i < 400; i++) begin
         stall = ($urandom_range(0, 7) == 0);
         flush = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 63) == 0);
         drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               pick(), ($urandom_range(0, 5) == 0) ? op_a : pick(), $urandom);
         if ($urandom_range(0, 5) == 0) op_b = op_a;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
